// File: rtl/gray_sched_pkg.sv
// gray_pipe_scheduler shared types and constants.
// Optional packet lock is enabled with GRAY_SCHED_PKT_LOCK_EN.
package gray_sched_pkg;
  localparam int RGB_W  = 24;
  localparam int GRAY_W = 8;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic src;
    logic last;
  } tag_t;

  typedef struct packed {
    logic [GRAY_W-1:0] gray;
    logic              src;
    logic              last;
  } fifo_entry_t;
endpackage

// File: rtl/gray_sched_fifo.sv
// First-word-fall-through FIFO for pipe results.
// Power-of-two depth; write while full is legal if a read happens.
module gray_sched_fifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gray_pipe_scheduler.sv
// Two-source scheduler around a fixed-latency grayscale pipe.
// Define GRAY_SCHED_PKT_LOCK_EN to lock grants per packet.
import gray_sched_pkg::*;

module gray_pipe_scheduler #(
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [RGB_W-1:0]  s0_rgb,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [RGB_W-1:0]  s1_rgb,
  input  logic              s1_last,
  output logic              pipe_valid_in,
  output logic [7:0]        pipe_r,
  output logic [7:0]        pipe_g,
  output logic [7:0]        pipe_b,
  input  logic              pipe_valid_out,
  input  logic [GRAY_W-1:0] pipe_gray,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [GRAY_W-1:0] m_gray,
  output logic              m_src,
  output logic              m_last,
  output logic              err
);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [OW-1:0]    occ;
  logic             credit_ok;
  logic             pop;
  logic             rr_ptr;
  logic             cand_ok;
  logic             cand_src;
  logic             grant;
  logic             grant_last;
  logic [RGB_W-1:0] grant_rgb;
  logic             src_q;
  logic             last_q;
  tag_t             tag_sr [PIPE_LAT];
  tag_t             tag_in;
  tag_t             tag_out;
  fifo_entry_t      wr_ent;
  fifo_entry_t      rd_ent;
  logic             f_empty;
  logic             f_full;
  logic [CW-1:0]    f_count;
  logic             unused_fifo;
`ifdef GRAY_SCHED_PKT_LOCK_EN
  logic             lock_q;
  logic             lock_src_q;
`endif

  assign credit_ok = (occ < OW'(FIFO_DEPTH));
  assign pop       = m_valid & m_ready;

  // pick the candidate source: pointer first, then the other
  always_comb begin
    cand_ok  = 1'b0;
    cand_src = rr_ptr;
`ifdef GRAY_SCHED_PKT_LOCK_EN
    if (lock_q) begin
      cand_src = lock_src_q;
      cand_ok  = lock_src_q ? s1_valid : s0_valid;
    end else
`endif
    if (rr_ptr ? s1_valid : s0_valid) begin
      cand_ok  = 1'b1;
      cand_src = rr_ptr;
    end else if (rr_ptr ? s0_valid : s1_valid) begin
      cand_ok  = 1'b1;
      cand_src = ~rr_ptr;
    end
  end

  assign grant      = credit_ok & cand_ok;
  assign s0_ready   = grant & (cand_src == SRC0);
  assign s1_ready   = grant & (cand_src == SRC1);
  assign grant_rgb  = cand_src ? s1_rgb : s0_rgb;
  assign grant_last = cand_src ? s1_last : s0_last;

  // round-robin pointer (and packet lock) advance on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SRC0;
`ifdef GRAY_SCHED_PKT_LOCK_EN
      lock_q     <= 1'b0;
      lock_src_q <= SRC0;
`endif
    end else if (grant) begin
      rr_ptr <= ~cand_src;
`ifdef GRAY_SCHED_PKT_LOCK_EN
      lock_q     <= ~grant_last;
      lock_src_q <= cand_src;
`endif
    end
  end

  // register the granted pixel onto the pipe inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_in <= 1'b0;
      pipe_r        <= '0;
      pipe_g        <= '0;
      pipe_b        <= '0;
      src_q         <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      pipe_valid_in <= grant;
      if (grant) begin
        pipe_r <= grant_rgb[23:16];
        pipe_g <= grant_rgb[15:8];
        pipe_b <= grant_rgb[7:0];
        src_q  <= cand_src;
        last_q <= grant_last;
      end
    end
  end

  assign tag_in  = '{valid: pipe_valid_in, src: src_q, last: last_q};
  assign tag_out = tag_sr[PIPE_LAT-1];

  // tags travel beside the pipe so they emerge with pipe_gray
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_sr[i] <= '0;
    end else begin
      tag_sr[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  // occupancy = in flight + buffered; bounds issue to FIFO space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // sticky flag when a tag emerges without pipe output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (tag_out.valid & ~pipe_valid_out) err <= 1'b1;
  end

  assign wr_ent = '{gray: pipe_gray, src: tag_out.src, last: tag_out.last};

  gray_sched_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_out.valid),
    .wr_data (wr_ent),
    .rd_en   (m_ready),
    .rd_data (rd_ent),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_count)
  );

  assign unused_fifo = &{1'b0, f_full, f_count};

  assign m_valid = ~f_empty;
  assign m_gray  = f_empty ? '0 : rd_ent.gray;
  assign m_src   = f_empty ? 1'b0 : rd_ent.src;
  assign m_last  = f_empty ? 1'b0 : rd_ent.last;
endmodule

// File: tb/tb_gray_pipe_scheduler.sv
// Scoreboard bench for gray_pipe_scheduler with a behavioural pipe.
// Build with GRAY_SCHED_PKT_LOCK_EN to exercise packet locking.
module tb_gray_pipe_scheduler;
  localparam int PL = 4;
  localparam int D  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid, s0_ready, s0_last;
  logic        s1_valid, s1_ready, s1_last;
  logic [23:0] s0_rgb, s1_rgb;
  logic        pipe_valid_in, pipe_valid_out;
  logic [7:0]  pipe_r, pipe_g, pipe_b, pipe_gray;
  logic        m_valid, m_ready, m_src, m_last, err;
  logic [7:0]  m_gray;

  always #5 clk = ~clk;

  gray_pipe_scheduler #(.PIPE_LAT(PL), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_rgb(s0_rgb), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_rgb(s1_rgb), .s1_last(s1_last),
    .pipe_valid_in(pipe_valid_in),
    .pipe_r(pipe_r), .pipe_g(pipe_g), .pipe_b(pipe_b),
    .pipe_valid_out(pipe_valid_out), .pipe_gray(pipe_gray),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_gray(m_gray), .m_src(m_src), .m_last(m_last),
    .err(err)
  );

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
    s = 72 * int'(p[23:16]) + 152 * int'(p[15:8]) + 16 * int'(p[7:0]);
    return 8'(s >> 8);
  endfunction

  // behavioural grayscale pipe, PL cycles, optionally losing its valid
  bit         kill = 0;
  logic [8:0] pst [PL];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PL; i++) pst[i] <= '0;
    end else begin
      pst[0] <= {pipe_valid_in, gray_of({pipe_r, pipe_g, pipe_b})};
      for (int i = 1; i < PL; i++) pst[i] <= pst[i-1];
    end
  end
  assign pipe_valid_out = pst[PL-1][8] & ~kill;
  assign pipe_gray      = pst[PL-1][7:0];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] g;
    logic       s;
    logic       l;
    int         acc;
  } exp_t;
  exp_t sbq[$];

  int         nacc = 0, nacc1 = 0, npop = 0, alt_bad = 0;
  bit         alt_on = 0;
  logic       prev_src = 1'b1;
  int         acc_cyc = 0, pop_cyc = 0;
  logic [7:0] pop_g;
  logic       pop_s, pop_l;
  logic       last_grant = 1'b1;
  logic       locked = 1'b0, lock_src = 1'b0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: reference arbitration/credit model plus output scoreboard
  initial forever begin
    logic [1:0] v;
    logic       ok, src, pref, credit, e0, e1, acc, a_src, a_last;
    logic [23:0] a_rgb;
    exp_t       e;
    @(negedge clk);
    if (!rst) begin
      v      = {s1_valid, s0_valid};
      credit = (sbq.size() < D);
      ok     = 1'b0;
      src    = 1'b0;
      if (locked) begin
        src = lock_src;
        ok  = v[lock_src];
      end else begin
        pref = ~last_grant;
        if (v[pref]) begin ok = 1'b1; src = pref; end
        else if (v[~pref]) begin ok = 1'b1; src = ~pref; end
      end
      e0 = credit & ok & (src == 1'b0);
      e1 = credit & ok & (src == 1'b1);
      chk("s0_ready", 32'(s0_ready), 32'(e0));
      chk("s1_ready", 32'(s1_ready), 32'(e1));

      acc    = 1'b0;
      a_src  = 1'b0;
      a_rgb  = s0_rgb;
      a_last = s0_last;
      if (s0_valid && s0_ready) acc = 1'b1;
      else if (s1_valid && s1_ready) begin
        acc = 1'b1; a_src = 1'b1; a_rgb = s1_rgb; a_last = s1_last;
      end
      if (acc) begin
        sbq.push_back('{g: gray_of(a_rgb), s: a_src, l: a_last, acc: cyc});
        nacc++;
        if (a_src) nacc1++;
        if (alt_on && a_src == prev_src) alt_bad++;
        prev_src   = a_src;
        acc_cyc    = cyc;
        last_grant = a_src;
`ifdef GRAY_SCHED_PKT_LOCK_EN
        locked   = ~a_last;
        lock_src = a_src;
`endif
      end

      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 32'(m_gray), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("m_gray", 32'(m_gray), 32'(e.g));
          chk("m_src",  32'(m_src),  32'(e.s));
          chk("m_last", 32'(m_last), 32'(e.l));
          chk("latency_min", 32'(cyc >= e.acc + PL + 2), 32'd1);
        end
        npop++;
        pop_cyc = cyc;
        pop_g   = m_gray;
        pop_s   = m_src;
        pop_l   = m_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sbq.delete();
    last_grant = 1'b1;
    locked     = 1'b0;
    prev_src   = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    m_ready  = 1'b1;
    for (int i = 0; i < 100 && sbq.size() > 0; i++) tick();
    tick();
    chk("drain_left", 32'(sbq.size()), 32'd0);
  endtask

  task automatic one_pixel(input logic src, input logic [23:0] rgb,
                           input logic last);
    int p0;
    p0 = npop;
    m_ready = 1'b1;
    if (src) begin s1_valid = 1'b1; s1_rgb = rgb; s1_last = last; end
    else begin s0_valid = 1'b1; s0_rgb = rgb; s0_last = last; end
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    for (int i = 0; i < 20 && npop == p0; i++) tick();
    chk("pop_seen", 32'(npop - p0), 32'd1);
  endtask

  initial begin
    int a0, a1, p0, mv;
    s0_valid = 0; s0_rgb = '0; s0_last = 0;
    s1_valid = 0; s1_rgb = '0; s1_last = 0;
    m_ready  = 0;
    rst      = 1'b1;
    repeat (3) tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_gray", 32'(m_gray), 0);
    chk("rst_m_src_last", 32'({m_src, m_last}), 0);
    chk("rst_pipe_vin", 32'(pipe_valid_in), 0);
    chk("rst_pipe_rgb", 32'({pipe_r, pipe_g, pipe_b}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'({s1_ready, s0_ready}), 0);
    rst = 1'b0;
    tick();

    // white pixel from s0
    one_pixel(1'b0, 24'hFFFFFF, 1'b0);
    chk("t1_latency", 32'(pop_cyc - acc_cyc), 32'(PL + 2));
    chk("t1_gray", 32'(pop_g), 32'hEF);
    chk("t1_src", 32'(pop_s), 0);
    chk("t1_err", 32'(err), 0);

    // red last pixel from s1
    one_pixel(1'b1, 24'hFF0000, 1'b1);
    chk("t4_gray", 32'(pop_g), 32'd71);
    chk("t4_last", 32'(pop_l), 1);
    chk("t4_src", 32'(pop_s), 1);

    // both sources busy: strict alternation at full rate
    a0 = nacc;
    alt_on = 1;
    alt_bad = 0;
    m_ready = 1;
    s0_valid = 1;
    s1_valid = 1;
    for (int i = 0; i < 30; i++) begin
      s0_rgb = 24'($urandom);
      s1_rgb = 24'($urandom);
      s0_last = 1'b0;
      s1_last = 1'b0;
      tick();
    end
    alt_on = 0;
    chk("t2_accepts", 32'(nacc - a0), 32'd30);
    chk("t2_alternate", 32'(alt_bad), 0);
    drain();

    // backpressure: credits limit acceptance to the FIFO depth
    a0 = nacc;
    m_ready = 0;
    s0_valid = 1;
    for (int i = 0; i < 20; i++) begin
      s0_rgb = 24'($urandom);
      tick();
    end
    chk("t3_accepts", 32'(nacc - a0), 32'(D));
    chk("t3_s0_ready", 32'(s0_ready), 0);
    p0 = npop;
    a1 = nacc;
    m_ready = 1;
    repeat (12) tick();
    chk("t3_pops", 32'(npop - p0 >= D), 1);
    chk("t3_resume", 32'(nacc > a1), 1);
    drain();

    // reset with pixels in flight and in the FIFO
    m_ready = 0;
    s0_valid = 1;
    a0 = nacc;
    for (int i = 0; i < 20 && nacc - a0 < 5; i++) begin
      s0_rgb = 24'($urandom);
      tick();
    end
    s0_valid = 0;
    repeat (2) tick();
    do_reset(2);
    m_ready = 1;
    mv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid) mv++;
    end
    chk("t5_no_output", 32'(mv), 0);
    s0_valid = 1;
    #1;
    chk("t5_s0_ready", 32'(s0_ready), 1);
    tick();
    drain();

`ifdef GRAY_SCHED_PKT_LOCK_EN
    // packet lock: s0 keeps the grant for its 4-pixel packet
    m_ready = 1;
    a0 = nacc - nacc1;
    a1 = nacc1;
    s0_valid = 1;
    s0_last = 0;
    for (int i = 0; i < 20 && (nacc - nacc1) - a0 < 4; i++) begin
      s0_last = ((nacc - nacc1) - a0 == 3);
      s0_rgb = 24'($urandom);
      tick();
      s1_valid = 1;
      s1_last = 0;
    end
    s0_valid = 0;
    chk("lock_s0_count", 32'((nacc - nacc1) - a0), 32'd4);
    chk("lock_s1_blocked", 32'(nacc1 - a1), 0);
    s1_last = 1;
    tick();
    chk("lock_s1_after", 32'(nacc1 - a1), 1);
    drain();
`endif

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      s0_valid = ($urandom_range(0, 3) != 0);
      s1_valid = ($urandom_range(0, 3) != 0);
      s0_rgb   = 24'($urandom);
      s1_rgb   = 24'($urandom);
      s0_last  = ($urandom_range(0, 3) == 0);
      s1_last  = ($urandom_range(0, 3) == 0);
      m_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();
    chk("rand_err", 32'(err), 0);

    // alignment checker: pipe loses its valid
    kill = 1;
    one_pixel(1'b0, 24'h123456, 1'b0);
    chk("err_set", 32'(err), 1);
    kill = 0;
    repeat (3) tick();
    chk("err_sticky", 32'(err), 1);
    do_reset(2);
    tick();
    chk("err_cleared", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
